// File: rtl/determ_sub_arb.sv
// determ_sub_arb: round-robin arbiter feeding a 2-stage (bitstream +/-1) minus FXP subtractor pipeline
module determ_sub_arb #(
    parameter int BIT_WIDTH = 16,
    parameter int INT_WIDTH = 1,
    parameter int NUM_REQ = 4,
    localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           a,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] b,
    input  logic [NUM_REQ-1:0]           mask,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [BIT_WIDTH-1:0]         y,
    output logic [ID_W-1:0]              y_id,
    output logic                         y_valid,
    input  logic                         y_ready
);
    localparam int FRAC = BIT_WIDTH - INT_WIDTH - 1;
    localparam logic [BIT_WIDTH-1:0] POS_ONE = BIT_WIDTH'(1) << FRAC;
    logic [NUM_REQ-1:0]   elig;
    logic [ID_W-1:0]      ptr, gid, k;
    logic                 hit;
    logic                 s1_v, s1_a;
    logic [BIT_WIDTH-1:0] s1_b, diff;
    logic [ID_W-1:0]      s1_id;
    logic                 s1_adv, s2_adv;
    assign elig   = req & mask;
    assign s2_adv = !y_valid || y_ready;
    assign s1_adv = !s1_v || s2_adv;
    assign diff   = (s1_a ? POS_ONE : -POS_ONE) - s1_b;
    // First eligible channel at or above the pointer, wrapping around
    always_comb begin
        gnt = '0;
        gid = '0;
        hit = 1'b0;
        k   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!hit && elig[k] && s1_adv && !RST) begin
                hit    = 1'b1;
                gid    = k;
                gnt[k] = 1'b1;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v    <= 1'b0;
            s1_a    <= 1'b0;
            s1_b    <= '0;
            s1_id   <= '0;
            ptr     <= '0;
            y       <= '0;
            y_id    <= '0;
            y_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v <= hit;
                if (hit) begin
                    s1_a  <= a[gid];
                    s1_b  <= b[gid*BIT_WIDTH +: BIT_WIDTH];
                    s1_id <= gid;
                    ptr   <= (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
                end
            end
            if (s2_adv) begin
                y       <= diff;
                y_id    <= s1_id;
                y_valid <= s1_v;
            end
        end
    end
endmodule
